// File: rtl/block_retire_decoder.sv
// rtl/block_retire_decoder.sv - retirement-block decoder: lane compaction, block FIFO, decoded output slot
// Optional continuity checker enabled by defining BLOCK_RETIRE_DECODER_CHECK_EN.
package mure_pkg;
  parameter int XLEN        = 32;
  parameter int IRETIRE_LEN = 8;
  parameter int ITYPE_LEN   = 4;
  parameter int CAUSE_LEN   = 5;
  parameter int PRIV_LEN    = 2;
endpackage

module block_retire_decoder
  import mure_pkg::*;
#(
  parameter int N          = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N-1:0]                valid_i,
  input  logic [N*IRETIRE_LEN-1:0]    iretire_i,
  input  logic [N-1:0]                ilastsize_i,
  input  logic [N*ITYPE_LEN-1:0]      itype_i,
  input  logic [CAUSE_LEN-1:0]        cause_i,
  input  logic [XLEN-1:0]             tval_i,
  input  logic [PRIV_LEN-1:0]         priv_i,
  input  logic [N*XLEN-1:0]           iaddr_i,
  output logic                        blk_valid_o,
  input  logic                        blk_ready_i,
  output logic [XLEN-1:0]             blk_iaddr_o,
  output logic [XLEN-1:0]             blk_last_iaddr_o,
  output logic [XLEN-1:0]             blk_next_iaddr_o,
  output logic [IRETIRE_LEN-1:0]      blk_iretire_o,
  output logic [ITYPE_LEN-1:0]        blk_itype_o,
  output logic [PRIV_LEN-1:0]         blk_priv_o,
  output logic [CAUSE_LEN-1:0]        blk_cause_o,
  output logic [XLEN-1:0]             blk_tval_o,
  output logic                        blk_discont_o,
  output logic                        overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0]        iaddr;
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
  } blk_t;

  blk_t            mem_q [FIFO_DEPTH];
  logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic [CW-1:0]   count;
  logic [CW-1:0]   free_cnt;

  blk_t            lane_blk [N];
  blk_t            comp [N];
  logic [CW-1:0]   push_cnt;
  logic            push_ok;
  logic            load;
  logic            pop;
  logic            bypass;
  logic            load_en;
  logic [CW-1:0]   skip;
  logic [CW-1:0]   fifo_push_n;
  blk_t            load_blk;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] last_pc;

  logic                   out_valid_q;
  logic [XLEN-1:0]        out_iaddr_q;
  logic [XLEN-1:0]        out_last_q;
  logic [XLEN-1:0]        out_next_q;
  logic [IRETIRE_LEN-1:0] out_iretire_q;
  logic [ITYPE_LEN-1:0]   out_itype_q;
  logic [PRIV_LEN-1:0]    out_priv_q;
  logic [CAUSE_LEN-1:0]   out_cause_q;
  logic [XLEN-1:0]        out_tval_q;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign free_cnt = CW'(FIFO_DEPTH) - count;

  // Exception payload only travels with a lane-0 exception/interrupt block.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      lane_blk[i].iaddr     = iaddr_i[i*XLEN +: XLEN];
      lane_blk[i].iretire   = iretire_i[i*IRETIRE_LEN +: IRETIRE_LEN];
      lane_blk[i].ilastsize = ilastsize_i[i];
      lane_blk[i].itype     = itype_i[i*ITYPE_LEN +: ITYPE_LEN];
      lane_blk[i].priv      = priv_i;
      if ((i == 0) && ((itype_i[i*ITYPE_LEN +: ITYPE_LEN] == ITYPE_LEN'(1)) ||
                       (itype_i[i*ITYPE_LEN +: ITYPE_LEN] == ITYPE_LEN'(2)))) begin
        lane_blk[i].cause = cause_i;
        lane_blk[i].tval  = tval_i;
      end else begin
        lane_blk[i].cause = '0;
        lane_blk[i].tval  = '0;
      end
    end
  end

  always_comb begin
    push_cnt = '0;
    for (int k = 0; k < N; k++) comp[k] = '0;
    for (int i = 0; i < N; i++) begin
      if (valid_i[i]) begin
        for (int k = 0; k < N; k++) begin
          if (CW'(k) == push_cnt) comp[k] = lane_blk[i];
        end
        push_cnt = push_cnt + CW'(1);
      end
    end
  end

  // Free space is judged on the registered count, so a same-cycle pop never makes room.
  assign push_ok     = (push_cnt <= free_cnt);
  assign load        = !out_valid_q || blk_ready_i;
  assign pop         = load && (count != '0);
  assign bypass      = load && (count == '0) && push_ok && (push_cnt != '0);
  assign load_en     = pop || bypass;
  assign skip        = bypass ? CW'(1) : '0;
  assign fifo_push_n = push_ok ? (push_cnt - skip) : '0;
  assign load_blk    = pop ? mem_q[rd_ptr_q[AW-1:0]] : comp[0];

  assign next_pc = load_blk.iaddr + XLEN'({load_blk.iretire, 1'b0});
  assign last_pc = next_pc - (load_blk.ilastsize ? XLEN'(4) : XLEN'(2));

  always_comb begin
    wr_ptr_d   = wr_ptr_q + fifo_push_n;
    rd_ptr_d   = rd_ptr_q + CW'(pop);
    overflow_d = overflow_q || !push_ok;
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < N; k++) begin
      if (push_ok && (CW'(k) >= skip) && (CW'(k) < push_cnt)) begin
        mem_q[wr_ptr_q[AW-1:0] + AW'(k) - skip[AW-1:0]] <= comp[k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q   <= 1'b0;
      out_iaddr_q   <= '0;
      out_last_q    <= '0;
      out_next_q    <= '0;
      out_iretire_q <= '0;
      out_itype_q   <= '0;
      out_priv_q    <= '0;
      out_cause_q   <= '0;
      out_tval_q    <= '0;
    end else if (load) begin
      out_valid_q <= load_en;
      if (load_en) begin
        out_iaddr_q   <= load_blk.iaddr;
        out_last_q    <= last_pc;
        out_next_q    <= next_pc;
        out_iretire_q <= load_blk.iretire;
        out_itype_q   <= load_blk.itype;
        out_priv_q    <= load_blk.priv;
        out_cause_q   <= load_blk.cause;
        out_tval_q    <= load_blk.tval;
      end
    end
  end

`ifdef BLOCK_RETIRE_DECODER_CHECK_EN
  typedef enum logic {S_IDLE, S_TRACK} state_e;

  state_e               state_q;
  logic [XLEN-1:0]      exp_pc_q;
  logic [ITYPE_LEN-1:0] prev_itype_q;
  logic                 discont_q;

  // Only a not-taken branch (itype 4) pins down the address of the following block.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      exp_pc_q     <= '0;
      prev_itype_q <= '0;
      discont_q    <= 1'b0;
    end else if (load_en) begin
      discont_q    <= (state_q == S_TRACK) && (prev_itype_q == ITYPE_LEN'(4)) &&
                      (load_blk.iaddr != exp_pc_q);
      exp_pc_q     <= next_pc;
      prev_itype_q <= load_blk.itype;
      if ((load_blk.itype == ITYPE_LEN'(1)) || (load_blk.itype == ITYPE_LEN'(2))) begin
        state_q <= S_IDLE;
      end else begin
        state_q <= S_TRACK;
      end
    end
  end

  assign blk_discont_o = discont_q;
`else
  assign blk_discont_o = 1'b0;
`endif

  assign blk_valid_o      = out_valid_q;
  assign blk_iaddr_o      = out_iaddr_q;
  assign blk_last_iaddr_o = out_last_q;
  assign blk_next_iaddr_o = out_next_q;
  assign blk_iretire_o    = out_iretire_q;
  assign blk_itype_o      = out_itype_q;
  assign blk_priv_o       = out_priv_q;
  assign blk_cause_o      = out_cause_q;
  assign blk_tval_o       = out_tval_q;
  assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_block_retire_decoder.sv
// tb/tb_block_retire_decoder.sv - self-checking bench for block_retire_decoder (N=2, FIFO_DEPTH=16)
module tb_block_retire_decoder;
  import mure_pkg::*;

  localparam int N = 2;
  localparam int D = 16;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic [N-1:0]             valid = '0;
  logic [N*IRETIRE_LEN-1:0] iretire = '0;
  logic [N-1:0]             ilastsize = '0;
  logic [N*ITYPE_LEN-1:0]   itype = '0;
  logic [CAUSE_LEN-1:0]     cause = '0;
  logic [XLEN-1:0]          tval = '0;
  logic [PRIV_LEN-1:0]      priv = '0;
  logic [N*XLEN-1:0]        iaddr = '0;
  logic                     ready = 1'b0;

  logic                   blk_valid_o;
  logic [XLEN-1:0]        blk_iaddr_o, blk_last_iaddr_o, blk_next_iaddr_o, blk_tval_o;
  logic [IRETIRE_LEN-1:0] blk_iretire_o;
  logic [ITYPE_LEN-1:0]   blk_itype_o;
  logic [PRIV_LEN-1:0]    blk_priv_o;
  logic [CAUSE_LEN-1:0]   blk_cause_o;
  logic                   blk_discont_o;
  logic                   overflow_o;

  always #5 clk = ~clk;

  block_retire_decoder #(.N(N), .FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .iretire_i(iretire),
    .ilastsize_i(ilastsize), .itype_i(itype), .cause_i(cause), .tval_i(tval),
    .priv_i(priv), .iaddr_i(iaddr), .blk_valid_o(blk_valid_o), .blk_ready_i(ready),
    .blk_iaddr_o(blk_iaddr_o), .blk_last_iaddr_o(blk_last_iaddr_o),
    .blk_next_iaddr_o(blk_next_iaddr_o), .blk_iretire_o(blk_iretire_o),
    .blk_itype_o(blk_itype_o), .blk_priv_o(blk_priv_o), .blk_cause_o(blk_cause_o),
    .blk_tval_o(blk_tval_o), .blk_discont_o(blk_discont_o), .overflow_o(overflow_o)
  );

  typedef struct {
    logic [XLEN-1:0]        iaddr, last, next, tval;
    logic [IRETIRE_LEN-1:0] iretire;
    logic [ITYPE_LEN-1:0]   itype;
    logic [CAUSE_LEN-1:0]   cause;
    logic [PRIV_LEN-1:0]    priv;
    logic                   discont;
  } exp_t;

  exp_t                 q[$];
  bit                   m_idle = 1'b1;
  bit                   m_ovf  = 1'b0;
  logic [XLEN-1:0]      m_exp  = '0;
  logic [ITYPE_LEN-1:0] m_prev = '0;
  int                   tests = 0;
  int                   fails = 0;
  int                   n_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_idle = 1'b1;
    m_ovf  = 1'b0;
  endtask

  // Everything held by the decoder is one in-order queue; the head sits in the output slot.
  task automatic model_step();
    int   pc, fc;
    exp_t e;
    logic [ITYPE_LEN-1:0] it;
    pc = 0;
    for (int i = 0; i < N; i++) if (valid[i]) pc++;
    fc = (q.size() > 0) ? q.size() - 1 : 0;
    if (q.size() > 0 && ready) void'(q.pop_front());
    if (pc > D - fc) begin
      m_ovf = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (valid[i]) begin
          it        = itype[i*ITYPE_LEN +: ITYPE_LEN];
          e.iaddr   = iaddr[i*XLEN +: XLEN];
          e.iretire = iretire[i*IRETIRE_LEN +: IRETIRE_LEN];
          e.itype   = it;
          e.priv    = priv;
          e.next    = XLEN'(e.iaddr + 2 * XLEN'(e.iretire));
          e.last    = XLEN'(e.next - (ilastsize[i] ? 4 : 2));
          if (i == 0 && (it == 1 || it == 2)) begin
            e.cause = cause;
            e.tval  = tval;
          end else begin
            e.cause = '0;
            e.tval  = '0;
          end
`ifdef BLOCK_RETIRE_DECODER_CHECK_EN
          e.discont = !m_idle && (m_prev == 4) && (e.iaddr != m_exp);
`else
          e.discont = 1'b0;
`endif
          m_idle = (it == 1 || it == 2);
          m_exp  = e.next;
          m_prev = it;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("valid", blk_valid_o, q.size() > 0);
    chk("overflow", overflow_o, m_ovf);
    if (q.size() > 0) begin
      chk("iaddr", blk_iaddr_o, q[0].iaddr);
      chk("last", blk_last_iaddr_o, q[0].last);
      chk("next", blk_next_iaddr_o, q[0].next);
      chk("iretire", blk_iretire_o, q[0].iretire);
      chk("itype", blk_itype_o, q[0].itype);
      chk("priv", blk_priv_o, q[0].priv);
      chk("cause", blk_cause_o, q[0].cause);
      chk("tval", blk_tval_o, q[0].tval);
      chk("discont", blk_discont_o, q[0].discont);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_lane(input int l, input logic [XLEN-1:0] a, input logic [IRETIRE_LEN-1:0] r,
                          input logic ls, input logic [ITYPE_LEN-1:0] it);
    iaddr[l*XLEN +: XLEN]                  = a;
    iretire[l*IRETIRE_LEN +: IRETIRE_LEN]  = r;
    ilastsize[l]                           = ls;
    itype[l*ITYPE_LEN +: ITYPE_LEN]        = it;
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", blk_valid_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_next", blk_next_iaddr_o, 0);
    chk("rst_discont", blk_discont_o, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // T1: single block appears one cycle after push
    valid = 2'b01; set_lane(0, 32'h1000, 8'd6, 1'b1, 4'd5); ready = 1'b0;
    tick();
    chk("t1_valid", blk_valid_o, 1);
    chk("t1_next", blk_next_iaddr_o, 32'h100C);
    chk("t1_last", blk_last_iaddr_o, 32'h1008);
    chk("t1_cause", blk_cause_o, 0);
    chk("t1_tval", blk_tval_o, 0);
    valid = '0; ready = 1'b1;
    tick();

    // T2: hole on lane 0 is skipped, exactly one block emitted
    valid = 2'b10; set_lane(1, 32'h2000, 8'd3, 1'b0, 4'd0);
    tick();
    chk("t2_iaddr", blk_iaddr_o, 32'h2000);
    valid = '0;
    tick();
    chk("t2_no_bogus", blk_valid_o, 0);

    // T4: continuity after a not-taken branch
    valid = 2'b01; set_lane(0, 32'h100, 8'd4, 1'b1, 4'd4); tick();
    set_lane(0, 32'h10C, 8'd2, 1'b0, 4'd0); tick();
`ifdef BLOCK_RETIRE_DECODER_CHECK_EN
    chk("t4_discont", blk_discont_o, 1);
`else
    chk("t4_discont", blk_discont_o, 0);
`endif
    set_lane(0, 32'h100, 8'd4, 1'b1, 4'd4); tick();
    set_lane(0, 32'h108, 8'd2, 1'b0, 4'd0); tick();
    chk("t4_cont", blk_discont_o, 0);

    // T5: exception payload, then unchecked block
    set_lane(0, 32'h500, 8'd1, 1'b0, 4'd1); cause = 5'h2; tval = 32'hDEAD; tick();
    chk("t5_cause", blk_cause_o, 5'h2);
    chk("t5_tval", blk_tval_o, 32'hDEAD);
    set_lane(0, 32'h9999_0000, 8'd5, 1'b1, 4'd0); tick();
    chk("t5_idle", blk_discont_o, 0);
    // exception itype on lane 1 does not carry cause/tval
    valid = 2'b11; cause = 5'h7; tval = 32'hBEEF;
    set_lane(0, 32'h600, 8'd2, 1'b0, 4'd0); set_lane(1, 32'h700, 8'd0, 1'b1, 4'd2);
    tick();
    valid = '0; tick();
    chk("lane1_cause", blk_cause_o, 0);
    tick();

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      valid = N'($urandom_range(0, 3));
      ready = ($urandom_range(0, 9) < 7);
      priv  = PRIV_LEN'($urandom);
      cause = CAUSE_LEN'($urandom);
      tval  = $urandom;
      for (int l = 0; l < N; l++) begin
        set_lane(l, ($urandom_range(0, 1) == 0) ? m_exp : $urandom,
                 ($urandom_range(0, 7) == 0) ? 8'd0 : IRETIRE_LEN'($urandom),
                 1'($urandom), ITYPE_LEN'($urandom_range(0, 6)));
      end
      tick();
    end
    valid = '0; ready = 1'b1;
    for (int c = 0; c < 40 && q.size() > 0; c++) tick();
    tick();
    chk("drain_empty", blk_valid_o, 0);

    // T6: asynchronous reset with blocks buffered
    ready = 1'b0;
    valid = 2'b11; set_lane(0, 32'h40, 8'd1, 1'b0, 4'd0); set_lane(1, 32'h44, 8'd1, 1'b0, 4'd4); tick();
    set_lane(0, 32'h80, 8'd1, 1'b0, 4'd4); set_lane(1, 32'h90, 8'd1, 1'b0, 4'd4); tick();
    valid = 2'b01; set_lane(0, 32'hA0, 8'd1, 1'b0, 4'd4); tick();
    valid = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("t6_valid_async", blk_valid_o, 0);
    chk("t6_overflow", overflow_o, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready = 1'b1;
    valid = 2'b01; set_lane(0, 32'h1234_5678, 8'd3, 1'b1, 4'd0); tick();
    chk("t6_first_unchecked", blk_discont_o, 0);
    valid = '0; tick();

    // T3: backpressure fills slot + FIFO, 18th push dropped
    ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      valid = 2'b01;
      set_lane(0, $urandom, IRETIRE_LEN'($urandom), 1'($urandom), ITYPE_LEN'($urandom_range(0, 6)));
      tick();
      if (c == 16) chk("t3_no_ovf_17", overflow_o, 0);
      if (c == 17) chk("t3_ovf_18", overflow_o, 1);
    end
    valid = '0; ready = 1'b1;
    n_out = 0;
    for (int c = 0; c < 19; c++) begin
      if (blk_valid_o) n_out++;
      tick();
    end
    chk("t3_count", n_out, 17);
    chk("t3_sticky", overflow_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
